cell_cfg_loader: RTL and testbench
==================================

Name: cell_cfg_loader

Overview:
Upstream configuration stage for a row of shifter/XOR cells. It accepts per-cell configuration words over a valid/ready stream into a shadow bank, then commits them atomically to the active registers that drive each cell's byPass/sel0/sel1/selOp. Cells never see a partially loaded configuration.

Parameters:
NUM_CELLS, 8, number of cells configured; one word per cell
CFG_W, 9, config word width: bit8 byPass, [7:5] sel0, [4:2] sel1, [1:0] selOp
IDX_W, $clog2(NUM_CELLS), word index counter width

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
cfg_start  in  1  pulse: begin a load sequence (honoured in IDLE only)
cfg_abort  in  1  abandon the current load; active config untouched
cfg_valid  in  1  cfg_data/cfg_last valid
cfg_ready  out  1  loader accepts a word this cycle
cfg_data  in  CFG_W  config word for cell at current index
cfg_last  in  1  marks final word of the sequence
byPass  out  NUM_CELLS  active bypass bit, bit i -> cell i
sel0  out  3*NUM_CELLS  active operand-0 select, [3i+2:3i] -> cell i
sel1  out  3*NUM_CELLS  active operand-1 select
selOp  out  2*NUM_CELLS  active op select (0 SLL, 1 SRL, 2 SRA, 3 XOR)
cfg_busy  out  1  state != IDLE
cfg_done  out  1  one-cycle pulse on commit
cfg_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset (async assert, sync-free release): state IDLE, idx=0, shadow cleared; active byPass all 1, sel0/sel1/selOp all 0 (each cell passes in0); cfg_ready=0, cfg_busy=0, cfg_done=0, cfg_err=0.
- FSM states IDLE, LOAD, COMMIT.
- IDLE: cfg_ready=0. cfg_start=1 -> LOAD, idx=0. cfg_valid ignored.
- LOAD: cfg_ready=1. Transfer on cfg_valid&&cfg_ready: shadow[idx]<=cfg_data, idx<=idx+1.
  - Transfer with idx==NUM_CELLS-1 and cfg_last=1 -> COMMIT.
  - Transfer with idx==NUM_CELLS-1 and cfg_last=0, or idx<NUM_CELLS-1 and cfg_last=1 -> cfg_err pulse next cycle, -> IDLE, no commit.
  - cfg_start in LOAD ignored.
- COMMIT: cfg_ready=0; active<=shadow for all cells in one edge; cfg_done pulses the same cycle the new values appear on outputs; -> IDLE. Load-to-output latency: 1 cycle after the last transfer edge.
- cfg_abort: in LOAD -> IDLE next edge, idx=0, any same-cycle transfer discarded; abort beats error. Ignored in IDLE and COMMIT; commit always completes.
- cfg_start and cfg_abort asserted together in IDLE: start wins.
- Active outputs are registers only, with no combinational path from cfg_data.
- idx never wraps; error/abort/commit reset it to 0.
- Reset mid-LOAD or mid-COMMIT: returns to reset values immediately; prior active config is lost and replaced by the reset config.

Optional Feature:
CFG_PARITY_EN: adds input cfg_par (1 bit, even parity over cfg_data). A transfer whose parity mismatches -> cfg_err pulse, -> IDLE, no commit; parity error beats cfg_last framing error. Without the macro, the port is absent and no parity check is performed.

Decomposition:
- Package clb_cfg_pkg holds:
  - CFG_W and the field offsets (BYP_BIT=8, SEL0_LSB=5, SEL1_LSB=2, OP_LSB=0).
  - The selOp encodings OP_SLL/OP_SRL/OP_SRA/OP_XOR.
  - The FSM state enum.
- One sub-module, cell_cfg_regbank: shadow and active arrays with a write port (idx, data, we) and a commit strobe; it unpacks fields onto the flattened output buses.

Test Plan:
- Reset, no stimulus -> byPass=8'hFF, sel0/sel1/selOp=0, cfg_ready=0, cfg_busy=0.
- Start, 8 back-to-back words; cell i gets {1'b0, i[2:0], (7-i), 2'd3}, cfg_last on the 8th -> cfg_done 1 cycle after the 8th transfer. Then byPass=0, sel0[3i+2:3i]=i, sel1=7-i, selOp all 3. Outputs unchanged before cfg_done.
- Same load with cfg_valid toggling 1/0 each cycle -> identical final config; cfg_done 1 cycle after the last accepted word.
- cfg_last on word 3 -> cfg_err pulse, FSM IDLE, previous active config unchanged. Separately, cfg_last=0 on word 8 -> cfg_err.
- cfg_abort after 5 words, then a full new load of selOp=1 for all cells -> only the new config appears; cfg_done only once.
- With CFG_PARITY_EN: word 2 sent with flipped cfg_par -> cfg_err, no commit. Async rst_n pulse during LOAD -> outputs return to reset values within the reset cycle.

Source files
------------

// File: rtl/clb_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Package : clb_cfg_pkg
// Desc    : Shared constants, field offsets and FSM encoding for the cell
//           configuration loader.
// Rev     : 1.0
// ============================================================================
package clb_cfg_pkg;

    localparam int CFG_W    = 9;
    localparam int BYP_BIT  = 8;
    localparam int SEL0_LSB = 5;
    localparam int SEL1_LSB = 2;
    localparam int OP_LSB   = 0;

    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cell_cfg_loader_if.sv
`default_nettype none
// ============================================================================
// Interface : cell_cfg_loader_if
// Desc      : Config word stream plus control/status for cell_cfg_loader.
//             Optional: CFG_PARITY_EN adds cfg_par (even parity on cfg_data).
// Rev       : 1.0
// ============================================================================
interface cell_cfg_loader_if #(
    parameter int CFG_W = 9
);
    logic             cfg_start;
    logic             cfg_abort;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_last;
`ifdef CFG_PARITY_EN
    logic             cfg_par;
`endif
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_err;

    modport master (
`ifdef CFG_PARITY_EN
        output cfg_par,
`endif
        output cfg_start, cfg_abort, cfg_valid, cfg_data, cfg_last,
        input  cfg_ready, cfg_busy, cfg_done, cfg_err
    );

    modport slave (
`ifdef CFG_PARITY_EN
        input  cfg_par,
`endif
        input  cfg_start, cfg_abort, cfg_valid, cfg_data, cfg_last,
        output cfg_ready, cfg_busy, cfg_done, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/cell_cfg_regbank.sv
`default_nettype none
// ============================================================================
// Module : cell_cfg_regbank
// Desc   : Shadow/active config arrays; commit copies all cells in one edge.
// Rev    : 1.0
// ============================================================================
module cell_cfg_regbank #(
    parameter int NUM_CELLS = 8,
    parameter int CFG_W     = 9,
    parameter int IDX_W     = $clog2(NUM_CELLS)
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   we,
    input  wire logic [IDX_W-1:0]       widx,
    input  wire logic [CFG_W-1:0]       wdata,
    input  wire logic                   commit,
    output logic [NUM_CELLS-1:0]        byPass,
    output logic [3*NUM_CELLS-1:0]      sel0,
    output logic [3*NUM_CELLS-1:0]      sel1,
    output logic [2*NUM_CELLS-1:0]      selOp
);
    import clb_cfg_pkg::*;

    // Reset config: bypass set, every select zero, so each cell passes in0
    localparam logic [CFG_W-1:0] c_RST_WORD = (CFG_W'(1) << BYP_BIT)
                                            | (CFG_W'(OP_SLL) << OP_LSB);

    logic [CFG_W-1:0] r_shadow [NUM_CELLS];
    logic [CFG_W-1:0] r_active [NUM_CELLS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= c_RST_WORD;
            end
        end else begin
            if (we)
                r_shadow[widx] <= wdata;
            if (commit)
                r_active <= r_shadow;
        end
    end

    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
        assign byPass[gi]        = r_active[gi][BYP_BIT];
        assign sel0[3*gi +: 3]   = r_active[gi][SEL0_LSB +: 3];
        assign sel1[3*gi +: 3]   = r_active[gi][SEL1_LSB +: 3];
        assign selOp[2*gi +: 2]  = r_active[gi][OP_LSB +: 2];
    end

endmodule
`default_nettype wire

// File: rtl/cell_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module : cell_cfg_loader
// Desc   : Streams per-cell config words into a shadow bank and commits them
//          atomically. Optional: CFG_PARITY_EN enables cfg_par checking.
// Rev    : 1.0
// ============================================================================
module cell_cfg_loader #(
    parameter int NUM_CELLS = 8,
    parameter int CFG_W     = clb_cfg_pkg::CFG_W,
    parameter int IDX_W     = $clog2(NUM_CELLS)
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    cell_cfg_loader_if.slave        cfg,
    output logic [NUM_CELLS-1:0]    byPass,
    output logic [3*NUM_CELLS-1:0]  sel0,
    output logic [3*NUM_CELLS-1:0]  sel1,
    output logic [2*NUM_CELLS-1:0]  selOp
);
    import clb_cfg_pkg::*;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_err, w_err_nxt;
    logic             r_done, w_done_nxt;
    logic             w_we, w_commit, w_par_bad, w_idx_last;

`ifdef CFG_PARITY_EN
    assign w_par_bad = ^{cfg.cfg_data, cfg.cfg_par};
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_idx_last = (r_idx == IDX_W'(NUM_CELLS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_err   <= w_err_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_we        = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg.cfg_start) begin
                    w_state_nxt = ST_LOAD;
                    w_idx_nxt   = '0;
                end
            end
            ST_LOAD: begin
                // Abort outranks any transfer or framing outcome in the same cycle
                if (cfg.cfg_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end else if (cfg.cfg_valid) begin
                    if (w_par_bad) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_we = 1'b1;
                        if (w_idx_last && cfg.cfg_last) begin
                            w_state_nxt = ST_COMMIT;
                            w_idx_nxt   = '0;
                        end else if (w_idx_last || cfg.cfg_last) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                            w_idx_nxt   = '0;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                end
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign cfg.cfg_ready = (r_state == ST_LOAD);
    assign cfg.cfg_busy  = (r_state != ST_IDLE);
    assign cfg.cfg_done  = r_done;
    assign cfg.cfg_err   = r_err;

    cell_cfg_regbank #(
        .NUM_CELLS (NUM_CELLS),
        .CFG_W     (CFG_W),
        .IDX_W     (IDX_W)
    ) u_regbank (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (w_we),
        .widx   (r_idx),
        .wdata  (cfg.cfg_data),
        .commit (w_commit),
        .byPass (byPass),
        .sel0   (sel0),
        .sel1   (sel1),
        .selOp  (selOp)
    );

endmodule
`default_nettype wire

// File: tb/tb_cell_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_cell_cfg_loader
// Desc   : Directed vector table plus hand sequences for cell_cfg_loader.
// Rev    : 1.0
// ============================================================================
module tb_cell_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byPass;
    logic [23:0] sel0, sel1;
    logic [15:0] selOp;

    always #5 clk = ~clk;

    cell_cfg_loader_if #(.CFG_W(9)) cif ();

    cell_cfg_loader #(.NUM_CELLS(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cfg    (cif),
        .byPass (byPass),
        .sel0   (sel0),
        .sel1   (sel1),
        .selOp  (selOp)
    );

    // Hand-derived bus images: pattern A cell i = {0, i, 7-i, 3}; pattern B = {0, 7-i, i, 1}
    localparam logic [23:0] A_S0 = 24'hFAC688;
    localparam logic [23:0] A_S1 = 24'h053977;
    localparam logic [15:0] A_OP = 16'hFFFF;
    localparam logic [15:0] B_OP = 16'h5555;
    localparam logic [8:0]  JUNK = {1'b1, 3'd5, 3'd5, 2'd2};

    typedef struct {
        logic        start, abort, valid, last;
        logic [8:0]  data;
        logic        exp_ready, exp_busy, exp_done, exp_err;
        logic [7:0]  exp_byp;
        logic [23:0] exp_s0, exp_s1;
        logic [15:0] exp_op;
    } vec_t;

    vec_t tbl [12];
    int   checks = 0, failures = 0, done_cnt = 0, err_cnt = 0;

    function automatic logic [8:0] word_a(input int i);
        return {1'b0, 3'(i), 3'(7 - i), 2'd3};
    endfunction

    function automatic logic [8:0] word_b(input int i);
        return {1'b0, 3'(7 - i), 3'(i), 2'd1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_cfg(input string tag, input logic [7:0] b, input logic [23:0] s0,
                           input logic [23:0] s1, input logic [15:0] op);
        chk({tag, ".byPass"}, {24'h0, byPass}, {24'h0, b});
        chk({tag, ".sel0"},   {8'h0, sel0},    {8'h0, s0});
        chk({tag, ".sel1"},   {8'h0, sel1},    {8'h0, s1});
        chk({tag, ".selOp"},  {16'h0, selOp},  {16'h0, op});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (cif.cfg_done) done_cnt++;
        if (cif.cfg_err)  err_cnt++;
    endtask

    task automatic drive_idle();
        cif.cfg_start = 1'b0;
        cif.cfg_abort = 1'b0;
        cif.cfg_valid = 1'b0;
        cif.cfg_last  = 1'b0;
        cif.cfg_data  = '0;
`ifdef CFG_PARITY_EN
        cif.cfg_par   = 1'b0;
`endif
    endtask

    task automatic send(input logic [8:0] data, input logic last);
        chk("ready_before_xfer", {31'h0, cif.cfg_ready}, 32'h1);
        cif.cfg_valid = 1'b1;
        cif.cfg_data  = data;
        cif.cfg_last  = last;
`ifdef CFG_PARITY_EN
        cif.cfg_par   = ^data;
`endif
        tick();
        cif.cfg_valid = 1'b0;
        cif.cfg_last  = 1'b0;
    endtask

    task automatic start_load();
        cif.cfg_start = 1'b1;
        tick();
        cif.cfg_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk_cfg("reset", 8'hFF, 24'h0, 24'h0, 16'h0);
        chk("reset.ready", {31'h0, cif.cfg_ready}, 32'h0);
        chk("reset.busy",  {31'h0, cif.cfg_busy},  32'h0);
        chk("reset.done",  {31'h0, cif.cfg_done},  32'h0);
        chk("reset.err",   {31'h0, cif.cfg_err},   32'h0);

        // Valid in IDLE must not start anything
        cif.cfg_valid = 1'b1;
        cif.cfg_data  = 9'h1FF;
        cif.cfg_last  = 1'b1;
        tick();
        drive_idle();
        chk("idle_valid.busy", {31'h0, cif.cfg_busy}, 32'h0);
        chk("idle_valid.err",  {31'h0, cif.cfg_err},  32'h0);

        // Back-to-back load of pattern A, checked cycle by cycle
        for (int k = 0; k < 12; k++) begin
            tbl[k].start     = (k == 0);
            tbl[k].abort     = 1'b0;
            tbl[k].valid     = (k >= 1 && k <= 8);
            tbl[k].last      = (k == 8);
            tbl[k].data      = (k >= 1 && k <= 8) ? word_a(k - 1) : 9'h0;
            tbl[k].exp_ready = (k >= 1 && k <= 8);
            tbl[k].exp_busy  = (k >= 1 && k <= 9);
            tbl[k].exp_done  = (k == 10);
            tbl[k].exp_err   = 1'b0;
            tbl[k].exp_byp   = (k >= 10) ? 8'h00 : 8'hFF;
            tbl[k].exp_s0    = (k >= 10) ? A_S0  : 24'h0;
            tbl[k].exp_s1    = (k >= 10) ? A_S1  : 24'h0;
            tbl[k].exp_op    = (k >= 10) ? A_OP  : 16'h0;
        end
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("tbl%0d.ready", k), {31'h0, cif.cfg_ready}, {31'h0, tbl[k].exp_ready});
            chk($sformatf("tbl%0d.busy", k),  {31'h0, cif.cfg_busy},  {31'h0, tbl[k].exp_busy});
            chk($sformatf("tbl%0d.done", k),  {31'h0, cif.cfg_done},  {31'h0, tbl[k].exp_done});
            chk($sformatf("tbl%0d.err", k),   {31'h0, cif.cfg_err},   {31'h0, tbl[k].exp_err});
            chk_cfg($sformatf("tbl%0d", k), tbl[k].exp_byp, tbl[k].exp_s0, tbl[k].exp_s1, tbl[k].exp_op);
            cif.cfg_start = tbl[k].start;
            cif.cfg_abort = tbl[k].abort;
            cif.cfg_valid = tbl[k].valid;
            cif.cfg_last  = tbl[k].last;
            cif.cfg_data  = tbl[k].data;
`ifdef CFG_PARITY_EN
            cif.cfg_par   = ^tbl[k].data;
`endif
            tick();
        end
        drive_idle();

        // Early cfg_last on word 3 -> framing error, active config untouched
        err_cnt = 0;
        done_cnt = 0;
        start_load();
        send(word_b(0), 1'b0);
        send(word_b(1), 1'b0);
        send(word_b(2), 1'b1);
        chk("early_last.err",  {31'h0, cif.cfg_err},  32'h1);
        chk("early_last.busy", {31'h0, cif.cfg_busy}, 32'h0);
        chk_cfg("early_last", 8'h00, A_S0, A_S1, A_OP);
        tick();
        chk("early_last.err_pulse", {31'h0, cif.cfg_err}, 32'h0);

        // Missing cfg_last on word 8 -> framing error
        start_load();
        for (int i = 0; i < 8; i++) send(word_b(i), 1'b0);
        chk("no_last.err",  {31'h0, cif.cfg_err},  32'h1);
        chk("no_last.busy", {31'h0, cif.cfg_busy}, 32'h0);
        tick();
        chk_cfg("no_last", 8'h00, A_S0, A_S1, A_OP);
        chk("framing.err_cnt",  err_cnt,  32'd2);
        chk("framing.done_cnt", done_cnt, 32'd0);

        // Abort after 5 words (same-cycle transfer discarded), then full load of B
        err_cnt = 0;
        done_cnt = 0;
        start_load();
        for (int i = 0; i < 5; i++) send(JUNK, 1'b0);
        cif.cfg_abort = 1'b1;
        cif.cfg_valid = 1'b1;
        cif.cfg_data  = JUNK;
        cif.cfg_last  = 1'b1;
`ifdef CFG_PARITY_EN
        cif.cfg_par   = ^JUNK;
`endif
        tick();
        drive_idle();
        chk("abort.busy", {31'h0, cif.cfg_busy}, 32'h0);
        chk("abort.err",  {31'h0, cif.cfg_err},  32'h0);
        cif.cfg_start = 1'b1;
        cif.cfg_abort = 1'b1;
        tick();
        drive_idle();
        chk("start_beats_abort.busy", {31'h0, cif.cfg_busy}, 32'h1);
        for (int i = 0; i < 8; i++) send(word_b(i), (i == 7));
        chk("commit_cycle.done", {31'h0, cif.cfg_done}, 32'h0);
        chk_cfg("commit_cycle", 8'h00, A_S0, A_S1, A_OP);
        cif.cfg_abort = 1'b1;
        tick();
        drive_idle();
        chk("b_load.done", {31'h0, cif.cfg_done}, 32'h1);
        chk("b_load.busy", {31'h0, cif.cfg_busy}, 32'h0);
        chk_cfg("b_load", 8'h00, A_S1, A_S0, B_OP);
        tick();
        chk("abort_seq.done_cnt", done_cnt, 32'd1);
        chk("abort_seq.err_cnt",  err_cnt,  32'd0);

        // Async reset outside a clock edge restores reset config at once
        rst_n = 1'b0;
        #2;
        chk_cfg("async_rst_idle", 8'hFF, 24'h0, 24'h0, 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Load A with valid toggling; a start during LOAD must be ignored
        start_load();
        for (int i = 0; i < 8; i++) begin
            if (i == 4) cif.cfg_start = 1'b1;
            send(word_a(i), (i == 7));
            cif.cfg_start = 1'b0;
            if (i != 7) begin
                if (i == 3) chk_cfg("toggle_mid", 8'hFF, 24'h0, 24'h0, 16'h0);
                tick();
            end
        end
        chk("toggle.commit_done", {31'h0, cif.cfg_done}, 32'h0);
        tick();
        chk("toggle.done", {31'h0, cif.cfg_done}, 32'h1);
        chk_cfg("toggle", 8'h00, A_S0, A_S1, A_OP);
        tick();

        // Async reset mid-LOAD
        start_load();
        for (int i = 0; i < 3; i++) send(word_b(i), 1'b0);
        rst_n = 1'b0;
        #2;
        chk_cfg("rst_mid_load", 8'hFF, 24'h0, 24'h0, 16'h0);
        chk("rst_mid_load.busy",  {31'h0, cif.cfg_busy},  32'h0);
        chk("rst_mid_load.ready", {31'h0, cif.cfg_ready}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("after_rst.busy", {31'h0, cif.cfg_busy}, 32'h0);

`ifdef CFG_PARITY_EN
        // Bad parity on word 2 -> error, no commit; then a clean load succeeds
        err_cnt = 0;
        done_cnt = 0;
        start_load();
        send(word_a(0), 1'b0);
        cif.cfg_valid = 1'b1;
        cif.cfg_data  = word_a(1);
        cif.cfg_last  = 1'b1;
        cif.cfg_par   = ~(^word_a(1));
        tick();
        drive_idle();
        chk("par.err",  {31'h0, cif.cfg_err},  32'h1);
        chk("par.busy", {31'h0, cif.cfg_busy}, 32'h0);
        tick();
        chk_cfg("par_nocommit", 8'hFF, 24'h0, 24'h0, 16'h0);
        start_load();
        for (int i = 0; i < 8; i++) send(word_a(i), (i == 7));
        tick();
        chk("par_ok.done", {31'h0, cif.cfg_done}, 32'h1);
        chk_cfg("par_ok", 8'h00, A_S0, A_S1, A_OP);
        chk("par.err_cnt", err_cnt, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
